hue_pwm_array: RTL and testbench



---
 rtl/hue_pwm_pkg.sv | 28 ++
 rtl/hue_to_level.sv | 42 ++++
 rtl/hue_pwm_array.sv | 141 ++++++++++++++
 tb/tb_hue_pwm_array.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hue_pwm_pkg.sv
// Shared types and helpers for the multi-LED hue PWM generator.
package hue_pwm_pkg;

  localparam int unsigned HUE_MAX = 360;

  typedef logic [8:0] hue_t;

  typedef enum logic [1:0] {
    ModeCycle   = 2'd0,
    ModeHold    = 2'd1,
    ModeBreathe = 2'd2,
    ModeOff     = 2'd3
  } mode_e;

  typedef enum logic {
    BrUp   = 1'b0,
    BrDown = 1'b1
  } breathe_e;

  // Modular hue addition; both operands are already below HUE_MAX.
  function automatic hue_t hue_add(input hue_t a, input hue_t b);
    logic [9:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 10'(HUE_MAX)) s = s - 10'(HUE_MAX);
    return s[8:0];
  endfunction

endpackage

// File: rtl/hue_to_level.sv
// Combinational hue-to-duty conversion for one colour channel, scaled by brightness.
module hue_to_level
  import hue_pwm_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  hue_t                h,
  input  logic [PWM_BITS-1:0] b,
  output logic [PWM_BITS-1:0] duty
);

  localparam int unsigned IW = PWM_BITS + 7;
  localparam int unsigned PW = 2 * PWM_BITS + 1;
  localparam logic [IW-1:0] Max = IW'((1 << PWM_BITS) - 1);
  localparam logic [IW-1:0] H60 = IW'(60);
  localparam logic [IW-1:0] H120 = IW'(120);
  localparam logic [IW-1:0] H240 = IW'(240);
  localparam logic [IW-1:0] H300 = IW'(300);

  logic [IW-1:0] hw;
  logic [IW-1:0] lvl;
  logic [PW-1:0] prod;

  always_comb begin
    hw = IW'(h);
    if (hw < H60) begin
      lvl = Max;
    end else if (hw < H120) begin
      lvl = Max - (Max * (hw - H60)) / H60;
    end else if (hw < H240) begin
      lvl = '0;
    end else if (hw < H300) begin
      lvl = (Max * (hw - H240)) / H60;
    end else begin
      lvl = Max;
    end
    // B+1 scaling makes full brightness an exact pass-through.
    prod = PW'(lvl) * (PW'(b) + PW'(1));
    duty = PWM_BITS'(prod >> PWM_BITS);
  end

endmodule

// File: rtl/hue_pwm_array.sv
// Multi-LED HSV colour-wheel PWM generator with brightness, hold, breathe and off modes.
module hue_pwm_array
  import hue_pwm_pkg::*;
#(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned NUM_LEDS    = 4,
  parameter int unsigned STEP_CYCLES = 33333,
  parameter int unsigned HUE_OFFSET  = 90
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] bright,
  input  logic [8:0]          hue_set,
  input  logic                hue_load,
  output logic [NUM_LEDS-1:0] pwm_r,
  output logic [NUM_LEDS-1:0] pwm_g,
  output logic [NUM_LEDS-1:0] pwm_b,
  output logic [8:0]          hue_out,
  output logic                period_start
);

  localparam int unsigned SW = $clog2(STEP_CYCLES);
  localparam logic [SW-1:0] StepLast = SW'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] Max = PWM_BITS'((1 << PWM_BITS) - 1);
  localparam logic [PWM_BITS-1:0] CntLast = Max - PWM_BITS'(1);

  typedef logic [NUM_LEDS-1:0][PWM_BITS-1:0] duty_arr_t;

  mode_e               mode_s;
  logic                tick, cnt_last;
  logic [SW-1:0]       step_q, step_d;
  hue_t                hue_q, hue_d;
  logic [PWM_BITS-1:0] lvl_q, lvl_d, b_eff;
  breathe_e            br_q, br_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  duty_arr_t           calc_r, calc_g, calc_b;
  duty_arr_t           duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;
  logic [NUM_LEDS-1:0] pwm_r_q, pwm_r_d, pwm_g_q, pwm_g_d, pwm_b_q, pwm_b_d;
  logic                period_start_q, period_start_d;

  assign mode_s = mode_e'(mode);

  for (genvar k = 0; k < NUM_LEDS; k++) begin : g_led
    localparam hue_t Off = hue_t'((k * HUE_OFFSET) % HUE_MAX);
    hue_t h_r, h_g, h_b;
    assign h_r = hue_add(hue_q, Off);
    assign h_g = hue_add(h_r, 9'd240);
    assign h_b = hue_add(h_r, 9'd120);

    hue_to_level #(.PWM_BITS(PWM_BITS)) u_lvl_r (.h(h_r), .b(b_eff), .duty(calc_r[k]));
    hue_to_level #(.PWM_BITS(PWM_BITS)) u_lvl_g (.h(h_g), .b(b_eff), .duty(calc_g[k]));
    hue_to_level #(.PWM_BITS(PWM_BITS)) u_lvl_b (.h(h_b), .b(b_eff), .duty(calc_b[k]));
  end

  always_comb begin
    tick   = (step_q == StepLast);
    step_d = tick ? '0 : step_q + 1'b1;

    hue_d = hue_q;
    if (hue_load && (hue_set < 9'(HUE_MAX))) begin
      hue_d = hue_set;
    end else if (tick && (mode_s == ModeCycle)) begin
      hue_d = hue_add(hue_q, 9'd1);
    end

    lvl_d = lvl_q;
    br_d  = br_q;
    if (tick && (mode_s == ModeBreathe)) begin
      if (br_q == BrUp) begin
        lvl_d = lvl_q + 1'b1;
        if (lvl_d == Max) br_d = BrDown;
      end else begin
        lvl_d = lvl_q - 1'b1;
        if (lvl_d == '0) br_d = BrUp;
      end
    end

    b_eff = (mode_s == ModeBreathe) ? lvl_q : bright;

    cnt_last = (cnt_q == CntLast);
    cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;

    // Duties only change at the period boundary so a running period is never disturbed.
    duty_r_d = duty_r_q;
    duty_g_d = duty_g_q;
    duty_b_d = duty_b_q;
    if (cnt_last) begin
      duty_r_d = (mode_s == ModeOff) ? '0 : calc_r;
      duty_g_d = (mode_s == ModeOff) ? '0 : calc_g;
      duty_b_d = (mode_s == ModeOff) ? '0 : calc_b;
    end

    pwm_r_d = '0;
    pwm_g_d = '0;
    pwm_b_d = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      pwm_r_d[k] = (cnt_q < duty_r_q[k]);
      pwm_g_d[k] = (cnt_q < duty_g_q[k]);
      pwm_b_d[k] = (cnt_q < duty_b_q[k]);
    end
    period_start_d = (cnt_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q         <= '0;
      hue_q          <= '0;
      lvl_q          <= '0;
      br_q           <= BrUp;
      cnt_q          <= '0;
      duty_r_q       <= '0;
      duty_g_q       <= '0;
      duty_b_q       <= '0;
      pwm_r_q        <= '0;
      pwm_g_q        <= '0;
      pwm_b_q        <= '0;
      period_start_q <= 1'b0;
    end else begin
      step_q         <= step_d;
      hue_q          <= hue_d;
      lvl_q          <= lvl_d;
      br_q           <= br_d;
      cnt_q          <= cnt_d;
      duty_r_q       <= duty_r_d;
      duty_g_q       <= duty_g_d;
      duty_b_q       <= duty_b_d;
      pwm_r_q        <= pwm_r_d;
      pwm_g_q        <= pwm_g_d;
      pwm_b_q        <= pwm_b_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_r        = pwm_r_q;
  assign pwm_g        = pwm_g_q;
  assign pwm_b        = pwm_b_q;
  assign hue_out      = hue_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_hue_pwm_array.sv
// Directed self-checking bench for hue_pwm_array (4-bit PWM, 2 LEDs, 4-cycle step, 120 deg offset).
module tb_hue_pwm_array;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [3:0] bright = 4'd15;
  logic [8:0] hue_set = 9'd0;
  logic       hue_load = 1'b0;
  logic [1:0] pwm_r, pwm_g, pwm_b;
  logic [8:0] hue_out;
  logic       period_start;

  int checks = 0;
  int failures = 0;
  int hi_r[2];
  int hi_g[2];
  int hi_b[2];

  always #5 clk = ~clk;

  hue_pwm_array #(
    .PWM_BITS(4),
    .NUM_LEDS(2),
    .STEP_CYCLES(4),
    .HUE_OFFSET(120)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .bright(bright),
    .hue_set(hue_set),
    .hue_load(hue_load),
    .pwm_r(pwm_r),
    .pwm_g(pwm_g),
    .pwm_b(pwm_b),
    .hue_out(hue_out),
    .period_start(period_start)
  );

  task automatic load_hue(input logic [8:0] val);
    @(negedge clk);
    hue_set  = val;
    hue_load = 1'b1;
    @(negedge clk);
    hue_load = 1'b0;
  endtask

  // Finds the next period start and counts high cycles of every output over one period.
  task automatic measure_period(input int change_at, input logic [1:0] nm, input logic [3:0] nb);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!period_start && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!period_start) begin
      checks++;
      failures++;
      $display("FAIL period_start_timeout got=0 want=1");
    end
    for (int k = 0; k < 2; k++) begin
      hi_r[k] = 0;
      hi_g[k] = 0;
      hi_b[k] = 0;
    end
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      if (i == change_at) begin
        mode   = nm;
        bright = nb;
      end
      for (int k = 0; k < 2; k++) begin
        hi_r[k] += int'(pwm_r[k]);
        hi_g[k] += int'(pwm_g[k]);
        hi_b[k] += int'(pwm_b[k]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 5;
    if (hue_out !== 9'd0) begin failures++; $display("FAIL reset_hue got=%0d want=0", hue_out); end
    if (pwm_r !== 2'b00) begin failures++; $display("FAIL reset_pwm_r got=%b want=00", pwm_r); end
    if (pwm_g !== 2'b00) begin failures++; $display("FAIL reset_pwm_g got=%b want=00", pwm_g); end
    if (pwm_b !== 2'b00) begin failures++; $display("FAIL reset_pwm_b got=%b want=00", pwm_b); end
    if (period_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_period_start got=%b want=0", period_start);
    end
    rst = 1'b0;
  endtask

  task automatic test_cycle();
    logic exp_ps;
    logic [8:0] exp_hue;
    mode   = 2'd0;
    bright = 4'd15;
    test_reset();
    for (int n = 1; n <= 1440; n++) begin
      @(negedge clk);
      if (n <= 45) begin
        exp_ps = ((n - 1) % 15 == 0);
        checks++;
        if (period_start !== exp_ps) begin
          failures++;
          $display("FAIL cycle_period_start n=%0d got=%b want=%b", n, period_start, exp_ps);
        end
      end
      if (n == 4 || n == 8 || n == 1436 || n == 1440) begin
        exp_hue = 9'((n / 4) % 360);
        checks++;
        if (hue_out !== exp_hue) begin
          failures++;
          $display("FAIL cycle_hue n=%0d got=%0d want=%0d", n, hue_out, exp_hue);
        end
      end
    end
  endtask

  task automatic test_hold_60();
    mode   = 2'd1;
    bright = 4'd15;
    load_hue(9'd60);
    checks++;
    if (hue_out !== 9'd60) begin failures++; $display("FAIL hold_load got=%0d want=60", hue_out); end
    measure_period(-1, 2'd1, 4'd15);
    measure_period(-1, 2'd1, 4'd15);
    checks += 6;
    if (hi_r[0] != 15) begin failures++; $display("FAIL h60_r0 got=%0d want=15", hi_r[0]); end
    if (hi_g[0] != 15) begin failures++; $display("FAIL h60_g0 got=%0d want=15", hi_g[0]); end
    if (hi_b[0] != 0) begin failures++; $display("FAIL h60_b0 got=%0d want=0", hi_b[0]); end
    if (hi_r[1] != 0) begin failures++; $display("FAIL h60_r1 got=%0d want=0", hi_r[1]); end
    if (hi_g[1] != 15) begin failures++; $display("FAIL h60_g1 got=%0d want=15", hi_g[1]); end
    if (hi_b[1] != 15) begin failures++; $display("FAIL h60_b1 got=%0d want=15", hi_b[1]); end
  endtask

  task automatic test_bright_change();
    mode   = 2'd1;
    bright = 4'd15;
    load_hue(9'd90);
    measure_period(-1, 2'd1, 4'd15);
    measure_period(-1, 2'd1, 4'd15);
    checks += 2;
    if (hi_r[0] != 8) begin failures++; $display("FAIL h90_r0_full got=%0d want=8", hi_r[0]); end
    if (hi_g[0] != 15) begin failures++; $display("FAIL h90_g0_full got=%0d want=15", hi_g[0]); end
    measure_period(7, 2'd1, 4'd7);
    checks++;
    if (hi_r[0] != 8) begin failures++; $display("FAIL h90_r0_midchange got=%0d want=8", hi_r[0]); end
    measure_period(-1, 2'd1, 4'd7);
    checks += 2;
    if (hi_r[0] != 4) begin failures++; $display("FAIL h90_r0_dim got=%0d want=4", hi_r[0]); end
    if (hi_g[0] != 7) begin failures++; $display("FAIL h90_g0_dim got=%0d want=7", hi_g[0]); end
  endtask

  task automatic test_load_invalid();
    load_hue(9'd400);
    checks++;
    if (hue_out !== 9'd90) begin failures++; $display("FAIL load_400 got=%0d want=90", hue_out); end
  endtask

  task automatic test_load_on_tick();
    mode = 2'd0;
    test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (hue_out !== 9'd0) begin failures++; $display("FAIL pre_tick_hue got=%0d want=0", hue_out); end
    hue_set  = 9'd200;
    hue_load = 1'b1;
    @(negedge clk);
    hue_load = 1'b0;
    checks++;
    if (hue_out !== 9'd200) begin failures++; $display("FAIL load_on_tick got=%0d want=200", hue_out); end
    repeat (4) @(negedge clk);
    checks++;
    if (hue_out !== 9'd201) begin failures++; $display("FAIL after_load_tick got=%0d want=201", hue_out); end
  endtask

  task automatic test_breathe();
    int exp_hi[9] = '{0, 3, 7, 11, 14, 12, 8, 4, 1};
    mode   = 2'd2;
    bright = 4'd3;
    test_reset();
    for (int m = 0; m < 9; m++) begin
      measure_period(-1, 2'd2, 4'd3);
      checks++;
      if (hi_r[0] != exp_hi[m]) begin
        failures++;
        $display("FAIL breathe_r0 period=%0d got=%0d want=%0d", m, hi_r[0], exp_hi[m]);
      end
    end
    checks++;
    if (hue_out !== 9'd0) begin failures++; $display("FAIL breathe_hue_frozen got=%0d want=0", hue_out); end
  endtask

  task automatic test_off_and_async_reset();
    mode   = 2'd1;
    bright = 4'd15;
    load_hue(9'd60);
    measure_period(-1, 2'd1, 4'd15);
    measure_period(5, 2'd3, 4'd15);
    checks++;
    if (hi_r[0] != 15) begin failures++; $display("FAIL off_current_r0 got=%0d want=15", hi_r[0]); end
    measure_period(-1, 2'd3, 4'd15);
    checks += 3;
    if (hi_r[0] != 0) begin failures++; $display("FAIL off_r0 got=%0d want=0", hi_r[0]); end
    if (hi_g[0] != 0) begin failures++; $display("FAIL off_g0 got=%0d want=0", hi_g[0]); end
    if (hi_b[1] != 0) begin failures++; $display("FAIL off_b1 got=%0d want=0", hi_b[1]); end
    mode = 2'd1;
    measure_period(-1, 2'd1, 4'd15);
    measure_period(-1, 2'd1, 4'd15);
    repeat (3) @(negedge clk);
    checks += 2;
    if (pwm_r !== 2'b01) begin failures++; $display("FAIL pre_rst_pwm_r got=%b want=01", pwm_r); end
    if (pwm_g !== 2'b11) begin failures++; $display("FAIL pre_rst_pwm_g got=%b want=11", pwm_g); end
    #1 rst = 1'b1;
    #1;
    checks += 4;
    if (pwm_r !== 2'b00) begin failures++; $display("FAIL async_rst_pwm_r got=%b want=00", pwm_r); end
    if (pwm_g !== 2'b00) begin failures++; $display("FAIL async_rst_pwm_g got=%b want=00", pwm_g); end
    if (pwm_b !== 2'b00) begin failures++; $display("FAIL async_rst_pwm_b got=%b want=00", pwm_b); end
    if (hue_out !== 9'd0) begin failures++; $display("FAIL async_rst_hue got=%0d want=0", hue_out); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_cycle();
    test_hold_60();
    test_bright_change();
    test_load_invalid();
    test_load_on_tick();
    test_breathe();
    test_off_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
